// File: rtl/prog_sequencer.sv
// prog_sequencer: program counter sequencer with LIFO return stack.
// Ports: Clk, Rst (sync, active-high), Cen step enable, Op/Target/Cond
//   operation inputs; PCOut registered PC; StackEmpty/StackFull
//   decoded from the stack pointer; Err sticky overflow/underflow.
// Option: define PROG_SEQ_RELBRANCH_EN for PC-relative BRANCH targets;
//   default build uses absolute BRANCH targets.
module prog_sequencer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int RESET_VEC = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Cen,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] Target,
    input  logic             Cond,
    output logic [WIDTH-1:0] PCOut,
    output logic             StackEmpty,
    output logic             StackFull,
    output logic             Err
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);
    localparam logic [WIDTH-1:0] PC_RST  = WIDTH'(RESET_VEC);

    typedef enum logic [2:0] {
        OP_NEXT   = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stk_q [DEPTH];

    logic             push;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] br_dest;
    logic [SPW-1:0]   sp_m1;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             empty;
    logic             full;

    assign empty  = (sp_q == '0);
    assign full   = (sp_q == SP_FULL);
    assign pc_inc = pc_q + 1'b1;
    assign sp_m1  = sp_q - 1'b1;

    // Push writes at sp, pop reads sp-1; both are only used when the
    // pointer is in range, so the truncation to IW bits is exact.
    assign wr_idx = sp_q[IW-1:0];
    assign rd_idx = sp_m1[IW-1:0];

`ifdef PROG_SEQ_RELBRANCH_EN
    // Target is already WIDTH bits, so sign extension to WIDTH is the
    // identity and two's complement add gives the mod 2^WIDTH result.
    assign br_dest = pc_q + Target;
`else
    assign br_dest = Target;
`endif

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (Cen) begin
            unique case (Op)
                OP_NEXT: begin
                    pc_d = pc_inc;
                end
                OP_JUMP: begin
                    pc_d = Target;
                end
                OP_BRANCH: begin
                    pc_d = Cond ? br_dest : pc_inc;
                end
                OP_CALL: begin
                    if (full) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = Target;
                        sp_d = sp_q + 1'b1;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end else begin
                        pc_d = stk_q[rd_idx];
                        sp_d = sp_m1;
                    end
                end
                default: begin
                    // NOP-stall: hold everything
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q  <= PC_RST;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Stack storage needs no reset: entries at or above sp are never
    // observed, and reset clears sp.
    always_ff @(posedge Clk) begin
        if (!Rst && push) begin
            stk_q[wr_idx] <= pc_inc;
        end
    end

    assign PCOut      = pc_q;
    assign StackEmpty = empty;
    assign StackFull  = full;
    assign Err        = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: directed test of prog_sequencer
// (WIDTH=8, DEPTH=4, RESET_VEC=0xFE).
module tb_prog_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             Clk;
    logic             Rst;
    logic             Cen;
    logic [2:0]       Op;
    logic [WIDTH-1:0] Target;
    logic             Cond;
    logic [WIDTH-1:0] PCOut;
    logic             StackEmpty;
    logic             StackFull;
    logic             Err;

    int total = 0;
    int bad   = 0;

    prog_sequencer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VEC(8'hFE)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Cen(Cen),
        .Op(Op),
        .Target(Target),
        .Cond(Cond),
        .PCOut(PCOut),
        .StackEmpty(StackEmpty),
        .StackFull(StackFull),
        .Err(Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic c, input logic [2:0] o,
                        input logic [7:0] t, input logic cd);
        Cen    = c;
        Op     = o;
        Target = t;
        Cond   = cd;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        step(1'b0, 3'd0, 8'h00, 1'b0);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (PCOut !== 8'hFE) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=fe", PCOut);
        end
        total++;
        if (StackEmpty !== 1'b1 || StackFull !== 1'b0 || Err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got e=%b f=%b err=%b exp 1 0 0",
                     StackEmpty, StackFull, Err);
        end
    endtask

    task automatic test_next_wrap();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'hFF;
        exp_pc[1] = 8'h00;
        exp_pc[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 8'h00, 1'b0);
            total++;
            if (PCOut !== exp_pc[i]) begin
                bad++;
                $display("FAIL next_wrap[%0d] got=%h exp=%h",
                         i, PCOut, exp_pc[i]);
            end
        end
    endtask

    task automatic test_cen_hold();
        step(1'b0, 3'd1, 8'h40, 1'b1);
        total++;
        if (PCOut !== 8'h01) begin
            bad++;
            $display("FAIL cen_hold got=%h exp=01", PCOut);
        end
        step(1'b0, 3'd3, 8'h77, 1'b1);
        total++;
        if (PCOut !== 8'h01 || StackEmpty !== 1'b1) begin
            bad++;
            $display("FAIL cen_hold_call got=%h e=%b exp=01 e=1",
                     PCOut, StackEmpty);
        end
        step(1'b1, 3'd1, 8'h40, 1'b0);
        total++;
        if (PCOut !== 8'h40) begin
            bad++;
            $display("FAIL cen_jump got=%h exp=40", PCOut);
        end
    endtask

    task automatic test_call_ret();
        logic [2:0] ops  [4];
        logic [7:0] tgts [4];
        logic [7:0] exp_pc [4];
        ops[0] = 3'd3; tgts[0] = 8'h10; exp_pc[0] = 8'h10;
        ops[1] = 3'd3; tgts[1] = 8'h20; exp_pc[1] = 8'h20;
        ops[2] = 3'd4; tgts[2] = 8'h99; exp_pc[2] = 8'h11;
        ops[3] = 3'd4; tgts[3] = 8'h99; exp_pc[3] = 8'h06;
        step(1'b1, 3'd1, 8'h05, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, ops[i], tgts[i], 1'b0);
            total++;
            if (PCOut !== exp_pc[i]) begin
                bad++;
                $display("FAIL call_ret[%0d] got=%h exp=%h",
                         i, PCOut, exp_pc[i]);
            end
        end
        total++;
        if (StackEmpty !== 1'b1 || Err !== 1'b0) begin
            bad++;
            $display("FAIL call_ret_end got e=%b err=%b exp e=1 err=0",
                     StackEmpty, Err);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] t;
        for (int i = 0; i < DEPTH; i++) begin
            t = 8'h80 + 8'(i);
            step(1'b1, 3'd3, t, 1'b0);
            total++;
            if (PCOut !== t) begin
                bad++;
                $display("FAIL ovf_call[%0d] got=%h exp=%h", i, PCOut, t);
            end
        end
        total++;
        if (StackFull !== 1'b1 || StackEmpty !== 1'b0 || Err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full got f=%b e=%b err=%b exp 1 0 0",
                     StackFull, StackEmpty, Err);
        end
        step(1'b1, 3'd3, 8'h90, 1'b0);
        total++;
        if (PCOut !== 8'h84 || Err !== 1'b1 || StackFull !== 1'b1) begin
            bad++;
            $display("FAIL ovf_extra got pc=%h err=%b f=%b exp 84 1 1",
                     PCOut, Err, StackFull);
        end
        step(1'b1, 3'd4, 8'h00, 1'b0);
        total++;
        if (PCOut !== 8'h83 || Err !== 1'b1 || StackFull !== 1'b0) begin
            bad++;
            $display("FAIL ovf_ret got pc=%h err=%b f=%b exp 83 1 0",
                     PCOut, Err, StackFull);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b1, 3'd1, 8'h30, 1'b0);
        step(1'b1, 3'd4, 8'h00, 1'b0);
        total++;
        if (PCOut !== 8'h31 || Err !== 1'b1 || StackEmpty !== 1'b1) begin
            bad++;
            $display("FAIL udf_ret got pc=%h err=%b e=%b exp 31 1 1",
                     PCOut, Err, StackEmpty);
        end
        step(1'b1, 3'd0, 8'h00, 1'b0);
        total++;
        if (PCOut !== 8'h32 || Err !== 1'b1) begin
            bad++;
            $display("FAIL udf_sticky got pc=%h err=%b exp 32 1",
                     PCOut, Err);
        end
        do_reset();
        total++;
        if (PCOut !== 8'hFE || Err !== 1'b0 || StackEmpty !== 1'b1) begin
            bad++;
            $display("FAIL udf_reset got pc=%h err=%b e=%b exp fe 0 1",
                     PCOut, Err, StackEmpty);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b1, 3'd3, 8'h60, 1'b0);
        step(1'b1, 3'd3, 8'h61, 1'b0);
        Rst = 1'b1;
        step(1'b1, 3'd3, 8'h62, 1'b0);
        Rst = 1'b0;
        total++;
        if (PCOut !== 8'hFE || StackEmpty !== 1'b1 || Err !== 1'b0) begin
            bad++;
            $display("FAIL rst_prio got pc=%h e=%b err=%b exp fe 1 0",
                     PCOut, StackEmpty, Err);
        end
        step(1'b1, 3'd4, 8'h00, 1'b0);
        total++;
        if (PCOut !== 8'hFF || Err !== 1'b1) begin
            bad++;
            $display("FAIL rst_discard got pc=%h err=%b exp ff 1",
                     PCOut, Err);
        end
        do_reset();
    endtask

    task automatic test_nop();
        step(1'b1, 3'd1, 8'h22, 1'b0);
        step(1'b1, 3'd3, 8'h70, 1'b0);
        for (int o = 5; o < 8; o++) begin
            step(1'b1, 3'(o), 8'hAA, 1'b1);
            total++;
            if (PCOut !== 8'h70 || StackEmpty !== 1'b0 || Err !== 1'b0) begin
                bad++;
                $display("FAIL nop_op%0d got pc=%h e=%b err=%b exp 70 0 0",
                         o, PCOut, StackEmpty, Err);
            end
        end
        step(1'b1, 3'd4, 8'h00, 1'b0);
        total++;
        if (PCOut !== 8'h23 || StackEmpty !== 1'b1) begin
            bad++;
            $display("FAIL nop_ret got pc=%h e=%b exp 23 1",
                     PCOut, StackEmpty);
        end
    endtask

    task automatic test_branch();
        logic [7:0] exp_taken;
`ifdef PROG_SEQ_RELBRANCH_EN
        exp_taken = 8'h40;
`else
        exp_taken = 8'hF0;
`endif
        step(1'b1, 3'd1, 8'h50, 1'b0);
        step(1'b1, 3'd2, 8'hF0, 1'b1);
        total++;
        if (PCOut !== exp_taken) begin
            bad++;
            $display("FAIL br_taken got=%h exp=%h", PCOut, exp_taken);
        end
        step(1'b1, 3'd1, 8'h50, 1'b0);
        step(1'b1, 3'd2, 8'hF0, 1'b0);
        total++;
        if (PCOut !== 8'h51) begin
            bad++;
            $display("FAIL br_not_taken got=%h exp=51", PCOut);
        end
    endtask

    initial begin
        Rst    = 1'b0;
        Cen    = 1'b0;
        Op     = 3'd0;
        Target = '0;
        Cond   = 1'b0;
        test_reset();
        test_next_wrap();
        test_cen_hold();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_reset_priority();
        test_nop();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the program counter and target width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, which sets the number of return-stack entries (2..16).
REQ-003 The block SHALL have parameter RESET_VEC, default 0, which sets the PC value loaded on reset.
REQ-004 Port Clk SHALL be an input, 1 bit wide: the single clock; all state changes on the rising edge.
REQ-005 Port Rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-006 Port Cen SHALL be an input, 1 bit wide: count/step enable.
REQ-007 Port Op SHALL be an input, 3 bits wide: the sequencing operation.
REQ-008 Port Target SHALL be an input, WIDTH bits wide: the jump/branch/call operand.
REQ-009 Port Cond SHALL be an input, 1 bit wide: the branch condition.
REQ-010 Port PCOut SHALL be an output, WIDTH bits wide: the registered program counter.
REQ-011 Port StackEmpty SHALL be an output, 1 bit wide, high when the return stack holds 0 entries.
REQ-012 Port StackFull SHALL be an output, 1 bit wide, high when the return stack holds DEPTH entries.
REQ-013 Port Err SHALL be an output, 1 bit wide: a sticky stack overflow/underflow flag.

Function
REQ-014 PCOut, the stack pointer and Err SHALL be registers that update only on the rising Clk edge; the new value is visible after the edge (1-cycle latency).
REQ-015 When Cen=0 and Rst=0, all state SHALL hold, whatever the values of Op, Target and Cond.
REQ-016 Op=000 (NEXT) SHALL set PC to PC+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-017 Op=001 (JUMP) SHALL set PC to Target.
REQ-018 Op=010 (BRANCH) SHALL set PC to the branch destination when Cond=1, else to PC+1.
REQ-019 Op=011 (CALL), when the stack is not full, SHALL push PC+1 (modulo 2^WIDTH) and set PC to Target.
REQ-020 Op=011 (CALL), when the stack is full, SHALL leave the stack unchanged, set PC to PC+1, and set Err.
REQ-021 Op=100 (RET), when the stack is not empty, SHALL pop the top entry into PC.
REQ-022 Op=100 (RET), when the stack is empty, SHALL leave the stack unchanged, set PC to PC+1, and set Err.
REQ-023 Op=101..111 SHALL hold PC and the stack (a NOP-stall), with no Err effect.
REQ-024 The return stack SHALL be LIFO; the stack pointer counts 0..DEPTH and never wraps.
REQ-025 StackEmpty and StackFull SHALL be decoded combinationally from the registered stack pointer only.
REQ-026 Once set, Err SHALL remain 1 until Rst; later legal operations do not clear it.
REQ-027 Entries of the stack array above the pointer SHALL NOT affect any output.

Reset
REQ-028 When Rst=1 at a rising Clk edge, the block SHALL set PCOut=RESET_VEC, stack pointer=0, and Err=0.
REQ-029 Rst SHALL take priority over Cen and Op, including mid-CALL or mid-RET sequences; the stack contents are discarded.
REQ-030 After reset, the outputs SHALL be StackEmpty=1 and StackFull=0.

Configuration
REQ-031 The macro PROG_SEQ_RELBRANCH_EN SHALL select the BRANCH destination mode.
REQ-032 With PROG_SEQ_RELBRANCH_EN defined, the BRANCH destination SHALL be PC + sign-extended Target (two's complement), modulo 2^WIDTH.
REQ-033 Without PROG_SEQ_RELBRANCH_EN, the BRANCH destination SHALL be Target (absolute); JUMP and CALL are always absolute.

Verification
REQ-034 The bench SHALL apply reset, then NEXT with Cen=1 for 3 cycles, with WIDTH=8 and RESET_VEC=0xFE, and SHALL check PCOut = 0xFE, 0xFF, 0x00, 0x01 (wrap).
REQ-035 The bench SHALL drive Cen=0 with Op=JUMP and Target=0x40, and SHALL check that PCOut is unchanged; it SHALL then set Cen=1 and check PCOut=0x40 on the next cycle.
REQ-036 The bench SHALL CALL 0x10 from PC=0x05, CALL 0x20, RET, RET, and SHALL check the PC sequence 0x10, 0x20, 0x11, 0x06, with StackEmpty=1 at the end.
REQ-037 The bench SHALL perform DEPTH+1 CALLs and SHALL check StackFull=1 after DEPTH of them; on the extra CALL it SHALL check PC=previous+1 and Err=1; it SHALL then perform a RET and check that Err stays 1.
REQ-038 The bench SHALL issue RET on an empty stack at PC=0x30 and SHALL check PC=0x31 and Err=1; it SHALL then assert Rst and check that Err=0 and PC=RESET_VEC.
REQ-039 With PROG_SEQ_RELBRANCH_EN defined, the bench SHALL set PC=0x50, Target=0xF0 and Cond=1, and SHALL check PC=0x40; with the macro undefined, the same stimulus SHALL give PC=0xF0, and Cond=0 SHALL give PC=0x51.
